// File: rtl/timer_pkg.sv
// Shared types for the loadable down-counter timer.
package timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} timer_state_t;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by PRE_DIV; tick is high on the last cycle of each group.
// Used by down_counter_timer only when PRESCALE_EN is defined.
module tick_prescaler #(
  parameter int PRE_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(PRE_DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(PRE_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tick = en && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr)
      r_cnt <= '0;
    else if (en)
      r_cnt <= tick ? '0 : r_cnt + CW'(1);
  end
endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter timer with one-cycle done pulse and optional auto-reload.
// Define PRESCALE_EN to decrement only every PRE_DIV run cycles.
module down_counter_timer
  import timer_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int PRE_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);
  timer_state_t     r_state, w_state_nxt;
  logic [WIDTH-1:0] r_count, w_count_nxt;
  logic [WIDTH-1:0] r_reload, w_reload_nxt;
  logic             r_done, w_done_nxt;
  logic             r_busy, w_busy_nxt;
  logic             w_tick;
  logic             w_reload_ok;

  assign w_reload_ok = auto_reload && (r_reload != '0);

`ifdef PRESCALE_EN
  logic w_run_en, w_presc_clr;

  // Frozen while pausing; restarted whenever a fresh run begins.
  assign w_run_en    = (r_state == RUN) && !pause && !load;
  assign w_presc_clr = load || ((r_state == IDLE || r_state == DONE) && w_state_nxt == RUN);

  tick_prescaler #(.PRE_DIV(PRE_DIV)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_presc_clr),
    .en   (w_run_en),
    .tick (w_tick)
  );
`else
  assign w_tick = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (load) begin
      if (r_state == RUN || r_state == PAUSE)
        w_state_nxt = pause ? PAUSE : RUN;
      else
        w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:  if (!pause && start && r_count != '0) w_state_nxt = RUN;
        RUN: begin
          if (pause)
            w_state_nxt = PAUSE;
          else if (r_count == '0 && !w_reload_ok)
            w_state_nxt = DONE;
        end
        PAUSE: if (!pause) w_state_nxt = RUN;
        DONE:  if (!pause && start && r_reload != '0) w_state_nxt = RUN;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_done_nxt   = 1'b0;
    w_busy_nxt   = (w_state_nxt == RUN) || (w_state_nxt == PAUSE);
    if (load) begin
      w_count_nxt  = load_val;
      w_reload_nxt = load_val;
    end else begin
      case (r_state)
        RUN: begin
          // Zero is held for one tick period before reloading.
          if (!pause && w_tick) begin
            if (r_count == '0) begin
              if (w_reload_ok) w_count_nxt = r_reload;
            end else begin
              w_count_nxt = r_count - WIDTH'(1);
              w_done_nxt  = (r_count == WIDTH'(1));
            end
          end
        end
        DONE: if (w_state_nxt == RUN) w_count_nxt = r_reload;
        default: ;
      endcase
    end
  end

  assign count = r_count;
  assign busy  = r_busy;
  assign done  = r_done;
endmodule
